// File: rtl/powerup_pkg.sv
// Shared definitions for the power-up scheduler, power-pack and paddle blocks.
package powerup_pkg;

    // Width of a power-pack mode code.
    localparam int MODE_W = 2;

    // Width of the frame counters used for delays and effect timers.
    localparam int CNT_W = 10;

    // Unit increment for frame counters.
    localparam logic [CNT_W-1:0] CNT_ONE = 10'd1;

    typedef logic [MODE_W-1:0] mode_t;

    // Power-pack effect codes.
    localparam mode_t MODE_SHRINK = 2'b00;
    localparam mode_t MODE_BOOST  = 2'b01;
    localparam mode_t MODE_IDK    = 2'b10;
    localparam mode_t MODE_SHIELD = 2'b11;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SPAWN = 2'd2,
        ST_LIVE  = 2'd3
    } sched_state_e;

    // Which player won the most recent simultaneous hit.
    typedef enum logic {
        TIE_P1 = 1'b0,
        TIE_P2 = 1'b1
    } tie_winner_e;

endpackage

// File: rtl/effect_timer.sv
// Per-player effect timer: holds the awarded mode and counts the effect down in frames.
module effect_timer
    import powerup_pkg::*;
#(
    parameter logic [CNT_W-1:0] EFFECT_TIME = 10'd480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              tick,
    input  logic              clear,
    input  logic [MODE_W-1:0] mode_in,
    output logic              active,
    output logic [MODE_W-1:0] mode
);

    logic [CNT_W-1:0] timer_q, timer_d;
    logic             active_q, active_d;
    mode_t            mode_q, mode_d;

    // Clear beats load, and a load beats a same-cycle expiry so a fresh award always sticks.
    always_comb begin
        timer_d  = timer_q;
        active_d = active_q;
        mode_d   = mode_q;
        if (clear) begin
            timer_d  = '0;
            active_d = 1'b0;
        end else if (load) begin
            timer_d  = EFFECT_TIME;
            active_d = 1'b1;
            mode_d   = mode_in;
        end else if (active_q && tick) begin
            timer_d  = timer_q - CNT_ONE;
            active_d = (timer_q != CNT_ONE);
        end
    end

    // Timer, active flag and mode register; the mode is kept after expiry.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q  <= '0;
            active_q <= 1'b0;
            mode_q   <= MODE_SHRINK;
        end else begin
            timer_q  <= timer_d;
            active_q <= active_d;
            mode_q   <= mode_d;
        end
    end

    assign active = active_q;
    assign mode   = mode_q;

endmodule

// File: rtl/powerup_scheduler.sv
// Decides when a power pack appears, how long it stays, and which player gets its effect.
module powerup_scheduler
    import powerup_pkg::*;
#(
    parameter logic [CNT_W-1:0] SPAWN_DELAY = 10'd300,
    parameter logic [CNT_W-1:0] LIVE_TIME   = 10'd600,
    parameter logic [CNT_W-1:0] EFFECT_TIME = 10'd480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              game_on,
    input  logic              hit1,
    input  logic              hit2,
    input  logic [MODE_W-1:0] pack_mode,
    output logic              spawn,
    output logic              eaten,
    output logic              live,
    output logic [MODE_W-1:0] p1_mode,
    output logic [MODE_W-1:0] p2_mode,
    output logic              p1_active,
    output logic              p2_active
);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    tie_winner_e      last_tie_q, last_tie_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             award1, award2;

    // State, shared frame counter and tie-break memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_tie_q <= TIE_P2;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_tie_q <= last_tie_d;
        end
    end

    // Next state, counter update and award decision; the counter restarts on every state change.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_tie_d = last_tie_q;
        award1     = 1'b0;
        award2     = 1'b0;
        cnt_inc    = cnt_q + CNT_ONE;
        if (!game_on) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_DELAY;
                    cnt_d   = '0;
                end
                ST_DELAY: begin
                    if (frame_tick) begin
                        if (cnt_inc == SPAWN_DELAY) begin
                            state_d = ST_SPAWN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                ST_SPAWN: begin
                    state_d = ST_LIVE;
                    cnt_d   = '0;
                end
                ST_LIVE: begin
                    if (hit1 || hit2) begin
                        if (hit1 && hit2) begin
                            if (last_tie_q == TIE_P2) begin
                                award1     = 1'b1;
                                last_tie_d = TIE_P1;
                            end else begin
                                award2     = 1'b1;
                                last_tie_d = TIE_P2;
                            end
                        end else begin
                            award1 = hit1;
                            award2 = hit2;
                        end
                        state_d = ST_DELAY;
                        cnt_d   = '0;
                    end else if (frame_tick) begin
                        if (cnt_inc == LIVE_TIME) begin
                            state_d = ST_DELAY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pack control outputs decoded straight from the state register.
    always_comb begin
        spawn = 1'b0;
        live  = 1'b0;
        eaten = 1'b1;
        case (state_q)
            ST_SPAWN: begin
                spawn = 1'b1;
                eaten = 1'b0;
            end
            ST_LIVE: begin
                live  = 1'b1;
                eaten = 1'b0;
            end
            default: begin
                spawn = 1'b0;
                live  = 1'b0;
                eaten = 1'b1;
            end
        endcase
    end

    effect_timer #(
        .EFFECT_TIME (EFFECT_TIME)
    ) u_timer_p1 (
        .clk     (clk),
        .reset   (reset),
        .load    (award1),
        .tick    (frame_tick),
        .clear   (!game_on),
        .mode_in (pack_mode),
        .active  (p1_active),
        .mode    (p1_mode)
    );

    effect_timer #(
        .EFFECT_TIME (EFFECT_TIME)
    ) u_timer_p2 (
        .clk     (clk),
        .reset   (reset),
        .load    (award2),
        .tick    (frame_tick),
        .clear   (!game_on),
        .mode_in (pack_mode),
        .active  (p2_active),
        .mode    (p2_mode)
    );

endmodule

// File: tb/tb_powerup_scheduler.sv
// Self-checking bench for powerup_scheduler with short timing parameters.
module tb_powerup_scheduler;

    localparam int SD  = 3;
    localparam int LT  = 4;
    localparam int EFF = 2;
    localparam int LONG_EFF = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       game_on;
    logic       hit1;
    logic       hit2;
    logic [1:0] pack_mode;

    logic       spawn, eaten, live, p1_active, p2_active;
    logic [1:0] p1_mode, p2_mode;
    logic       l_spawn, l_eaten, l_live, l_p1_active, l_p2_active;
    logic [1:0] l_p1_mode, l_p2_mode;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pack phase plus frames remaining for each player's effect.
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_SPAWN = 2;
    localparam int M_SHOWN = 3;
    int         m_phase;
    int         m_frames;
    int         m_rem1;
    int         m_rem2;
    logic [1:0] m_mode1;
    logic [1:0] m_mode2;
    bit         m_p1_wins_tie;

    powerup_scheduler #(
        .SPAWN_DELAY (10'(SD)),
        .LIVE_TIME   (10'(LT)),
        .EFFECT_TIME (10'(EFF))
    ) dut (
        .clk (clk), .reset (reset), .frame_tick (frame_tick), .game_on (game_on),
        .hit1 (hit1), .hit2 (hit2), .pack_mode (pack_mode),
        .spawn (spawn), .eaten (eaten), .live (live),
        .p1_mode (p1_mode), .p2_mode (p2_mode),
        .p1_active (p1_active), .p2_active (p2_active)
    );

    // Second instance with a long effect so an effect can survive into the next LIVE window.
    powerup_scheduler #(
        .SPAWN_DELAY (10'(SD)),
        .LIVE_TIME   (10'(LT)),
        .EFFECT_TIME (10'(LONG_EFF))
    ) dut_long (
        .clk (clk), .reset (reset), .frame_tick (frame_tick), .game_on (game_on),
        .hit1 (hit1), .hit2 (hit2), .pack_mode (pack_mode),
        .spawn (l_spawn), .eaten (l_eaten), .live (l_live),
        .p1_mode (l_p1_mode), .p2_mode (l_p2_mode),
        .p1_active (l_p1_active), .p2_active (l_p2_active)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit a1, a2;
        if (reset) begin
            m_phase = M_IDLE; m_frames = 0; m_rem1 = 0; m_rem2 = 0;
            m_mode1 = 2'b00; m_mode2 = 2'b00; m_p1_wins_tie = 1'b1;
            return;
        end
        if (!game_on) begin
            m_phase = M_IDLE; m_frames = 0; m_rem1 = 0; m_rem2 = 0;
            return;
        end
        a1 = 1'b0;
        a2 = 1'b0;
        if (m_phase == M_SHOWN && (hit1 || hit2)) begin
            if (hit1 && hit2) begin
                a1 = m_p1_wins_tie;
                a2 = !m_p1_wins_tie;
                m_p1_wins_tie = !m_p1_wins_tie;
            end else begin
                a1 = hit1;
                a2 = hit2;
            end
        end
        if (a1) begin m_rem1 = EFF; m_mode1 = pack_mode; end
        else if (frame_tick && m_rem1 > 0) m_rem1--;
        if (a2) begin m_rem2 = EFF; m_mode2 = pack_mode; end
        else if (frame_tick && m_rem2 > 0) m_rem2--;
        case (m_phase)
            M_IDLE: begin m_phase = M_WAIT; m_frames = 0; end
            M_WAIT: if (frame_tick) begin
                m_frames++;
                if (m_frames == SD) begin m_phase = M_SPAWN; m_frames = 0; end
            end
            M_SPAWN: begin m_phase = M_SHOWN; m_frames = 0; end
            default: begin
                if (a1 || a2) begin
                    m_phase = M_WAIT; m_frames = 0;
                end else if (frame_tick) begin
                    m_frames++;
                    if (m_frames == LT) begin m_phase = M_WAIT; m_frames = 0; end
                end
            end
        endcase
    endtask

    // One clock: advance the model on the current inputs, then sample just after the edge.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic t, input logic h1, input logic h2, input logic [1:0] m);
        frame_tick = t;
        hit1       = h1;
        hit2       = h2;
        pack_mode  = m;
        step();
        frame_tick = 1'b0;
        hit1       = 1'b0;
        hit2       = 1'b0;
    endtask

    // From DELAY with an empty count: SPAWN_DELAY ticks, then the SPAWN cycle.
    task automatic reach_live();
        for (int i = 0; i < SD; i++) drive(1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic restart_game();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        reset   = 1'b0;
        game_on = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1; game_on = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 2'b11);
        drive(1'b1, 1'b1, 1'b1, 2'b11);
        n_checks++; if (spawn !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_spawn: got %b want 0", spawn); end
        n_checks++; if (live !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_live: got %b want 0", live); end
        n_checks++; if (eaten !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_eaten: got %b want 1", eaten); end
        n_checks++; if ({p1_mode, p2_mode} !== 4'b0000) begin n_errors++; $display("[TB] FAIL reset_modes: got %b want 0000", {p1_mode, p2_mode}); end
        n_checks++; if ({p1_active, p2_active} !== 2'b00) begin n_errors++; $display("[TB] FAIL reset_active: got %b want 00", {p1_active, p2_active}); end
    endtask

    task automatic test_spawn();
        reset = 1'b0; game_on = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        n_checks++; if (eaten !== 1'b1 || spawn !== 1'b0) begin n_errors++; $display("[TB] FAIL delay_entry: eaten=%b spawn=%b want 1/0", eaten, spawn); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (spawn !== 1'b0) begin n_errors++; $display("[TB] FAIL early_spawn: got %b want 0", spawn); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (spawn !== 1'b1 || eaten !== 1'b0 || live !== 1'b0) begin n_errors++; $display("[TB] FAIL spawn_pulse: spawn/eaten/live=%b%b%b want 100", spawn, eaten, live); end
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        n_checks++; if (spawn !== 1'b0 || eaten !== 1'b0 || live !== 1'b1) begin n_errors++; $display("[TB] FAIL live_entry: spawn/eaten/live=%b%b%b want 001", spawn, eaten, live); end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < LT - 1; i++) drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (live !== 1'b1) begin n_errors++; $display("[TB] FAIL live_before_timeout: got %b want 1", live); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (live !== 1'b0 || eaten !== 1'b1) begin n_errors++; $display("[TB] FAIL timeout: live/eaten=%b%b want 01", live, eaten); end
        n_checks++; if ({p1_active, p2_active} !== 2'b00) begin n_errors++; $display("[TB] FAIL timeout_no_award: got %b want 00", {p1_active, p2_active}); end
        for (int i = 0; i < SD; i++) drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (spawn !== 1'b1) begin n_errors++; $display("[TB] FAIL respawn: got %b want 1", spawn); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < LT - 1; i++) drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (live !== 1'b1) begin n_errors++; $display("[TB] FAIL spawn_tick_ignored: live=%b want 1", live); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (live !== 1'b0) begin n_errors++; $display("[TB] FAIL second_timeout: live=%b want 0", live); end
    endtask

    task automatic test_award();
        reach_live();
        drive(1'b0, 1'b1, 1'b0, 2'b11);
        n_checks++; if (eaten !== 1'b1 || live !== 1'b0) begin n_errors++; $display("[TB] FAIL award_eaten: eaten/live=%b%b want 10", eaten, live); end
        n_checks++; if (p1_mode !== 2'b11 || p1_active !== 1'b1) begin n_errors++; $display("[TB] FAIL award_p1: mode=%b active=%b want 11/1", p1_mode, p1_active); end
        n_checks++; if (p2_active !== 1'b0) begin n_errors++; $display("[TB] FAIL award_p2_idle: got %b want 0", p2_active); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (p1_active !== 1'b1) begin n_errors++; $display("[TB] FAIL effect_mid: got %b want 1", p1_active); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (p1_active !== 1'b0 || p1_mode !== 2'b11) begin n_errors++; $display("[TB] FAIL effect_expire: active=%b mode=%b want 0/11", p1_active, p1_mode); end
        drive(1'b0, 1'b1, 1'b1, 2'b10);
        n_checks++; if ({p1_active, p2_active} !== 2'b00 || p1_mode !== 2'b11) begin n_errors++; $display("[TB] FAIL hit_in_delay: act=%b mode=%b want 00/11", {p1_active, p2_active}, p1_mode); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b1, 1'b0, 2'b01);
        n_checks++; if (p1_active !== 1'b0 || live !== 1'b1) begin n_errors++; $display("[TB] FAIL hit_in_spawn: active=%b live=%b want 0/1", p1_active, live); end
    endtask

    task automatic test_tie();
        restart_game();
        reach_live();
        drive(1'b0, 1'b1, 1'b1, 2'b01);
        n_checks++; if ({p1_active, p2_active} !== 2'b10 || p1_mode !== 2'b01) begin n_errors++; $display("[TB] FAIL first_tie: act=%b p1_mode=%b want 10/01", {p1_active, p2_active}, p1_mode); end
        reach_live();
        drive(1'b0, 1'b1, 1'b1, 2'b10);
        n_checks++; if ({p1_active, p2_active} !== 2'b01 || p2_mode !== 2'b10) begin n_errors++; $display("[TB] FAIL second_tie: act=%b p2_mode=%b want 01/10", {p1_active, p2_active}, p2_mode); end
        n_checks++; if (p1_mode !== 2'b01) begin n_errors++; $display("[TB] FAIL tie_p1_hold: got %b want 01", p1_mode); end
    endtask

    task automatic test_award_vs_expiry();
        restart_game();
        reach_live();
        drive(1'b0, 1'b0, 1'b1, 2'b01);
        n_checks++; if (l_p2_active !== 1'b1 || l_p2_mode !== 2'b01) begin n_errors++; $display("[TB] FAIL long_award: act=%b mode=%b want 1/01", l_p2_active, l_p2_mode); end
        reach_live();
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (l_p2_active !== 1'b1 || l_live !== live) begin n_errors++; $display("[TB] FAIL long_last_frame: act=%b live=%b want 1/%b", l_p2_active, l_live, live); end
        drive(1'b1, 1'b0, 1'b1, 2'b11);
        n_checks++; if (l_p2_active !== 1'b1 || l_p2_mode !== 2'b11) begin n_errors++; $display("[TB] FAIL award_beats_expiry: act=%b mode=%b want 1/11", l_p2_active, l_p2_mode); end
        for (int i = 0; i < LONG_EFF - 1; i++) drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (l_p2_active !== 1'b1) begin n_errors++; $display("[TB] FAIL reload_full: act=%b want 1", l_p2_active); end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (l_p2_active !== 1'b0 || l_p2_mode !== 2'b11) begin n_errors++; $display("[TB] FAIL reload_expire: act=%b mode=%b want 0/11", l_p2_active, l_p2_mode); end
        n_checks++; if (l_spawn !== spawn || l_eaten !== eaten) begin n_errors++; $display("[TB] FAIL long_fsm_agree: %b%b vs %b%b", l_spawn, l_eaten, spawn, eaten); end
    endtask

    task automatic test_game_off();
        restart_game();
        reach_live();
        drive(1'b0, 1'b1, 1'b0, 2'b10);
        reach_live();
        n_checks++; if (l_p1_active !== 1'b1 || live !== 1'b1) begin n_errors++; $display("[TB] FAIL pre_drop: act=%b live=%b want 1/1", l_p1_active, live); end
        game_on = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        n_checks++; if (live !== 1'b0 || eaten !== 1'b1 || spawn !== 1'b0) begin n_errors++; $display("[TB] FAIL drop_idle: live/eaten/spawn=%b%b%b want 010", live, eaten, spawn); end
        n_checks++; if (l_p1_active !== 1'b0 || p1_active !== 1'b0) begin n_errors++; $display("[TB] FAIL drop_clear: %b%b want 00", l_p1_active, p1_active); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b00);
            n_checks++; if (spawn !== 1'b0 || eaten !== 1'b1) begin n_errors++; $display("[TB] FAIL off_hold: spawn/eaten=%b%b want 01", spawn, eaten); end
        end
        game_on = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < SD - 1; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b00);
            n_checks++; if (spawn !== 1'b0) begin n_errors++; $display("[TB] FAIL resume_early: got %b want 0", spawn); end
        end
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (spawn !== 1'b1) begin n_errors++; $display("[TB] FAIL resume_spawn: got %b want 1", spawn); end
    endtask

    task automatic test_reset_priority();
        restart_game();
        reach_live();
        drive(1'b0, 1'b1, 1'b0, 2'b10);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 2'b00);
        n_checks++; if (p1_active !== 1'b0 || p1_mode !== 2'b00 || eaten !== 1'b1) begin n_errors++; $display("[TB] FAIL reset_mid_effect: act=%b mode=%b eaten=%b want 0/00/1", p1_active, p1_mode, eaten); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00);
        reach_live();
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'b11);
        n_checks++; if (live !== 1'b0 || p1_active !== 1'b0 || p1_mode !== 2'b00) begin n_errors++; $display("[TB] FAIL reset_mid_live: live=%b act=%b mode=%b want 0/0/00", live, p1_active, p1_mode); end
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic e_spawn, e_live, e_eaten;
        restart_game();
        for (int i = 0; i < 800; i++) begin
            reset   = ($urandom_range(0, 299) == 0);
            game_on = ($urandom_range(0, 99) < 97);
            drive(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < 20),
                  1'($urandom_range(0, 99) < 20), 2'($urandom_range(0, 3)));
            e_spawn = (m_phase == M_SPAWN);
            e_live  = (m_phase == M_SHOWN);
            e_eaten = !(e_spawn || e_live);
            n_checks++; if ({spawn, live, eaten} !== {e_spawn, e_live, e_eaten}) begin n_errors++; $display("[TB] FAIL rand_pack cyc %0d: spawn/live/eaten=%b want %b", i, {spawn, live, eaten}, {e_spawn, e_live, e_eaten}); end
            n_checks++; if (p1_active !== (m_rem1 > 0) || p1_mode !== m_mode1) begin n_errors++; $display("[TB] FAIL rand_p1 cyc %0d: act=%b mode=%b want %b/%b", i, p1_active, p1_mode, (m_rem1 > 0), m_mode1); end
            n_checks++; if (p2_active !== (m_rem2 > 0) || p2_mode !== m_mode2) begin n_errors++; $display("[TB] FAIL rand_p2 cyc %0d: act=%b mode=%b want %b/%b", i, p2_active, p2_mode, (m_rem2 > 0), m_mode2); end
        end
        reset = 1'b0;
        game_on = 1'b1;
    endtask

    initial begin
        reset = 1'b1; game_on = 1'b0; frame_tick = 1'b0;
        hit1 = 1'b0; hit2 = 1'b0; pack_mode = 2'b00;
        #2;
        test_reset();
        test_spawn();
        test_timeout();
        test_award();
        test_tie();
        test_award_vs_expiry();
        test_game_off();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
